// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sharing slice.
//   - ALU function codes (code 0 is ADD, used as the idle value on the ALU bus)
//   - flag bit positions inside the 4-bit {overflow, negative, carry, zero} vector
//   - FSM state type for alu_share_arbiter
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SRL  = 4'd11;
  localparam logic [3:0] ALU_SRA  = 4'd12;
  localparam logic [3:0] ALU_SLLV = 4'd13;
  localparam logic [3:0] ALU_SRLV = 4'd14;
  localparam logic [3:0] ALU_SRAV = 4'd15;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_NEG   = 2;
  localparam int unsigned FLAG_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req : request bits, one per requester
//   ptr : index where the search starts (must be < NREQ)
//   gnt : one-hot grant to the first set req at or after ptr (wrapping), or zero
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] rot_gnt;
  logic            found;

  // Rotate so that rot[k] is request (ptr+k) mod NREQ, pick the lowest set
  // bit, then rotate the grant back into requester order.
  always_comb begin
    rot     = NREQ'({req, req} >> ptr);
    rot_gnt = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        rot_gnt[k] = 1'b1;
        found      = 1'b1;
      end
    end
    gnt = NREQ'(({rot_gnt, rot_gnt} << ptr) >> NREQ);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between NREQ requesters.
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/req_ready      : per-requester request handshake (ready one-hot or zero)
//   req_a/req_b/req_func     : packed per-requester operands and function code
//   resp_valid/resp_ready    : per-requester response handshake (valid one-hot or zero)
//   resp_res/resp_flags      : registered result and {ovf, neg, carry, zero}
//   alu_a/alu_b/alu_func     : ALU inputs, zero outside the execute cycle
//   alu_res/alu_*            : ALU result and flags
// Flow: IDLE (grant + capture) -> EXEC (drive ALU, register result) -> RESP (hold until accepted).
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = 32,
  parameter int FUNC_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ*FUNC_W-1:0]   req_func,
  output logic [NREQ-1:0]          resp_valid,
  input  logic [NREQ-1:0]          resp_ready,
  output logic [DATA_W-1:0]        resp_res,
  output logic [3:0]               resp_flags,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [FUNC_W-1:0]        alu_func,
  input  logic [DATA_W-1:0]        alu_res,
  input  logic                     alu_zero,
  input  logic                     alu_carry,
  input  logic                     alu_negative,
  input  logic                     alu_overflow
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  gidx;
  logic [PTR_W-1:0]  win_idx;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   resp_valid_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [FUNC_W-1:0] op_func;
  logic [DATA_W-1:0] res_q;
  logic [3:0]        flags_q;
  logic              resp_hs;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) win_idx = PTR_W'(i);
    end
  end

  // Only combinational input-to-output path; gated so nothing is granted during reset.
  assign req_ready = (state == ST_IDLE && !rst) ? gnt : '0;

  // resp_valid_q is one-hot on the granted requester, so masking picks out its ready.
  assign resp_hs = (state == ST_RESP) && ((resp_ready & resp_valid_q) != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      gidx         <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_func      <= '0;
      res_q        <= '0;
      flags_q      <= '0;
      resp_valid_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid != '0) begin
            op_a    <= req_a[win_idx*DATA_W +: DATA_W];
            op_b    <= req_b[win_idx*DATA_W +: DATA_W];
            op_func <= req_func[win_idx*FUNC_W +: FUNC_W];
            gidx    <= win_idx;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q                <= alu_res;
          flags_q[FLAG_ZERO]   <= alu_zero;
          flags_q[FLAG_CARRY]  <= alu_carry;
          flags_q[FLAG_NEG]    <= alu_negative;
          flags_q[FLAG_OVF]    <= alu_overflow;
          resp_valid_q         <= NREQ'(1) << gidx;
          state                <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_hs) begin
            resp_valid_q <= '0;
            ptr          <= (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outside EXEC the ALU sees ADD 0,0.
  assign alu_a      = (state == ST_EXEC) ? op_a    : '0;
  assign alu_b      = (state == ST_EXEC) ? op_b    : '0;
  assign alu_func   = (state == ST_EXEC) ? op_func : '0;
  assign resp_valid = resp_valid_q;
  assign resp_res   = res_q;
  assign resp_flags = flags_q;

endmodule
